traffic_lamp_monitor: RTL and testbench

- Downstream stage of the 4-way traffic light sequencer.
- Consumes the per-direction 3-bit light codes (1=green, 2=yellow, 3=red) and drives one-hot R/Y/G lamp outputs.
- Checks every cycle for unsafe or illegal code patterns. On the first violation it latches a fault and forces all four directions to flashing red until reset.

---
 rtl/traffic_lamp_monitor.sv | 189 ++++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
// Decodes the 4-way sequencer light codes (1=green, 2=yellow, 3=red) into
// one-hot {R,Y,G} lamp drives and watches for unsafe code patterns. The first
// violation latches a fault and all directions fall back to flashing red.
// Build option: define TRAFFIC_FAULT_CLEAR_EN to add the fault_clr input,
// which lets a fault be cleared while the sequencer is driving all-red.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal operation: decode codes to lamps, run all checks
// ST_FAULT | failsafe: checks ignored, all lamps flash red until cleared

module traffic_lamp_monitor #(
   parameter int STUCK_MAX  = 64,
   parameter int BLINK_HALF = 4
) (
   input  logic       clk,
   input  logic       rst,
`ifdef TRAFFIC_FAULT_CLEAR_EN
   input  logic       fault_clr,
`endif
   input  logic [2:0] east,
   input  logic [2:0] south,
   input  logic [2:0] west,
   input  logic [2:0] north,
   output logic [2:0] lamp_e,
   output logic [2:0] lamp_s,
   output logic [2:0] lamp_w,
   output logic [2:0] lamp_n,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [3:0] fault_dir
);

   localparam int SW = $clog2(STUCK_MAX);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_MAX - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_CONFLICT = 3'd1;
   localparam logic [2:0] FC_INVALID  = 3'd2;
   localparam logic [2:0] FC_SEQ      = 3'd3;
   localparam logic [2:0] FC_STUCK    = 3'd4;

   typedef enum logic {ST_RUN, ST_FAULT} state_t;

   state_t             state;
   logic [3:0][2:0]    code;      // index 0=E, 1=S, 2=W, 3=N
   logic [3:0][2:0]    prev_q;
   logic [SW-1:0]      stuck_cnt;
   logic [BW-1:0]      blink_cnt;
   logic               phase_on;

   logic [3:0]         green;
   logic [3:0]         bad;
   logic [3:0]         seq;
   logic               all_eq;
   logic               hit;
   logic [2:0]         hit_code;
   logic [3:0]         hit_dir;
   logic               clr_hit;
   logic               blink_wrap;
   logic               phase_nxt;

   assign code = {north, west, south, east};

   function automatic logic [2:0] decode(input logic [2:0] c);
      case (c)
         3'd1:    decode = 3'b001;
         3'd2:    decode = 3'b010;
         default: decode = LAMP_RED;
      endcase
   endfunction

   // Safety checks on current codes vs. previous codes, highest priority wins
   always_comb begin
      green    = '0;
      bad      = '0;
      seq      = '0;
      hit      = 1'b0;
      hit_code = FC_NONE;
      hit_dir  = '0;
      for (int i = 0; i < 4; i++) begin
         green[i] = (code[i] == 3'd1);
         bad[i]   = (code[i] == 3'd0) || (code[i] > 3'd3);
         seq[i]   = (prev_q[i] == 3'd1) && (code[i] == 3'd3);
      end
      all_eq = (code == prev_q);
      if ((green & (green - 4'd1)) != 4'd0) begin
         hit      = 1'b1;
         hit_code = FC_CONFLICT;
         hit_dir  = green;
      end else if (|bad) begin
         hit      = 1'b1;
         hit_code = FC_INVALID;
         hit_dir  = bad;
      end else if (|seq) begin
         hit      = 1'b1;
         hit_code = FC_SEQ;
         hit_dir  = seq;
      end else if (all_eq && (stuck_cnt == STUCK_LAST)) begin
         hit      = 1'b1;
         hit_code = FC_STUCK;
         hit_dir  = '0;
      end
   end

`ifdef TRAFFIC_FAULT_CLEAR_EN
   assign clr_hit = fault_clr && (code == {4{3'd3}});
`else
   assign clr_hit = 1'b0;
`endif

   // Lamps are driven from the phase the blink counter is about to enter so
   // that the entry edge counts as the first lit cycle.
   assign blink_wrap = (blink_cnt == BLINK_LAST);
   assign phase_nxt  = blink_wrap ? ~phase_on : phase_on;

   // Monitor FSM with registered lamp and fault outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_RUN;
         fault      <= 1'b0;
         fault_code <= FC_NONE;
         fault_dir  <= '0;
         lamp_e     <= LAMP_RED;
         lamp_s     <= LAMP_RED;
         lamp_w     <= LAMP_RED;
         lamp_n     <= LAMP_RED;
         prev_q     <= {4{3'd3}};
         stuck_cnt  <= '0;
         blink_cnt  <= '0;
         phase_on   <= 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (hit) begin
                  state      <= ST_FAULT;
                  fault      <= 1'b1;
                  fault_code <= hit_code;
                  fault_dir  <= hit_dir;
                  lamp_e     <= LAMP_RED;
                  lamp_s     <= LAMP_RED;
                  lamp_w     <= LAMP_RED;
                  lamp_n     <= LAMP_RED;
                  blink_cnt  <= '0;
                  phase_on   <= 1'b1;
               end else begin
                  lamp_e    <= decode(east);
                  lamp_s    <= decode(south);
                  lamp_w    <= decode(west);
                  lamp_n    <= decode(north);
                  prev_q    <= code;
                  stuck_cnt <= all_eq ? stuck_cnt + 1'b1 : '0;
               end
            end
            ST_FAULT: begin
               if (clr_hit) begin
                  state      <= ST_RUN;
                  fault      <= 1'b0;
                  fault_code <= FC_NONE;
                  fault_dir  <= '0;
                  lamp_e     <= decode(east);
                  lamp_s     <= decode(south);
                  lamp_w     <= decode(west);
                  lamp_n     <= decode(north);
                  prev_q     <= code;
                  stuck_cnt  <= '0;
                  blink_cnt  <= '0;
                  phase_on   <= 1'b1;
               end else begin
                  blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
                  phase_on  <= phase_nxt;
                  lamp_e    <= phase_nxt ? LAMP_RED : LAMP_OFF;
                  lamp_s    <= phase_nxt ? LAMP_RED : LAMP_OFF;
                  lamp_w    <= phase_nxt ? LAMP_RED : LAMP_OFF;
                  lamp_n    <= phase_nxt ? LAMP_RED : LAMP_OFF;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the edge just taken.

module tb_traffic_lamp_monitor;

   localparam logic [11:0] ALL_RED = {4{3'b100}};

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] east, south, west, north;
   logic [2:0] lamp_e, lamp_s, lamp_w, lamp_n;
   logic       fault;
   logic [2:0] fault_code;
   logic [3:0] fault_dir;
   logic [11:0] lamps_all;
`ifdef TRAFFIC_FAULT_CLEAR_EN
   logic       fault_clr;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign lamps_all = {lamp_n, lamp_w, lamp_s, lamp_e};

   traffic_lamp_monitor #(.STUCK_MAX(64), .BLINK_HALF(4)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef TRAFFIC_FAULT_CLEAR_EN
      .fault_clr  (fault_clr),
`endif
      .east       (east),
      .south      (south),
      .west       (west),
      .north      (north),
      .lamp_e     (lamp_e),
      .lamp_s     (lamp_s),
      .lamp_w     (lamp_w),
      .lamp_n     (lamp_n),
      .fault      (fault),
      .fault_code (fault_code),
      .fault_dir  (fault_dir)
   );

   function automatic logic [2:0] dec(input logic [2:0] c);
      case (c)
         3'd1:    dec = 3'b001;
         3'd2:    dec = 3'b010;
         3'd3:    dec = 3'b100;
         default: dec = 3'bxxx;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] e, input logic [2:0] s,
                        input logic [2:0] w, input logic [2:0] n);
      east  = e;
      south = s;
      west  = w;
      north = n;
   endtask

   task automatic do_reset();
      rst = 1'b1;
`ifdef TRAFFIC_FAULT_CLEAR_EN
      fault_clr = 1'b0;
`endif
      drive(3, 3, 3, 3);
      tick();
      rst = 1'b0;
   endtask

   task automatic step_nom(input logic [2:0] e, input logic [2:0] s,
                           input logic [2:0] w, input logic [2:0] n);
      drive(e, s, w, n);
      tick();
      chk("nom_lamps", 16'(lamps_all), 16'({dec(n), dec(w), dec(s), dec(e)}));
      chk("nom_fault", 16'(fault), 16'd0);
   endtask

   task automatic run_nominal(input int rounds);
      logic [2:0] c [4];
      for (int r = 0; r < rounds; r++) begin
         for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 4; i++) c[i] = 3'd3;
            c[d] = 3'd1;
            for (int k = 0; k < 8; k++) step_nom(c[0], c[1], c[2], c[3]);
            c[d] = 3'd2;
            c[(d + 1) % 4] = 3'd2;
            for (int k = 0; k < 5; k++) step_nom(c[0], c[1], c[2], c[3]);
         end
      end
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_lamps", 16'(lamps_all), 16'(ALL_RED));
      chk("rst_fault", 16'(fault), 16'd0);
      chk("rst_code", 16'(fault_code), 16'd0);
      chk("rst_dir", 16'(fault_dir), 16'd0);

      // nominal sequence, two rounds
      run_nominal(2);

      // conflict straight out of the nominal sequence
      drive(1, 1, 3, 3);
      tick();
      chk("conf_fault", 16'(fault), 16'd1);
      chk("conf_code", 16'(fault_code), 16'd1);
      chk("conf_dir", 16'(fault_dir), 16'b0011);
      chk("conf_lamps", 16'(lamps_all), 16'(ALL_RED));
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("conf_blink", 16'(lamps_all), (k < 4) ? 16'(ALL_RED) : 16'd0);
      end

      // reset during the dark half of the blink
      rst = 1'b1;
      drive(3, 3, 3, 3);
      tick();
      rst = 1'b0;
      chk("rstf_fault", 16'(fault), 16'd0);
      chk("rstf_code", 16'(fault_code), 16'd0);
      chk("rstf_dir", 16'(fault_dir), 16'd0);
      chk("rstf_lamps", 16'(lamps_all), 16'(ALL_RED));
      run_nominal(1);

      // green straight to red, then blink timing with checks ignored
      do_reset();
      step_nom(1, 3, 3, 3);
      drive(3, 3, 3, 3);
      tick();
      chk("seq_fault", 16'(fault), 16'd1);
      chk("seq_code", 16'(fault_code), 16'd3);
      chk("seq_dir", 16'(fault_dir), 16'b0001);
      chk("seq_lamps", 16'(lamps_all), 16'(ALL_RED));
      for (int k = 1; k <= 8; k++) begin
         drive(1, 1, 0, 3);
         tick();
         chk("seq_blink", 16'(lamps_all), (k < 4 || k == 8) ? 16'(ALL_RED) : 16'd0);
         chk("seq_frozen", 16'({fault_code, fault_dir}), 16'({3'd3, 4'b0001}));
      end

      // invalid code
      do_reset();
      drive(3, 3, 3, 0);
      tick();
      chk("inv_code", 16'(fault_code), 16'd2);
      chk("inv_dir", 16'(fault_dir), 16'b1000);
      chk("inv_lamps", 16'(lamps_all), 16'(ALL_RED));

      // conflict beats invalid
      do_reset();
      drive(1, 5, 1, 3);
      tick();
      chk("pri_code", 16'(fault_code), 16'd1);
      chk("pri_dir", 16'(fault_dir), 16'b0101);

      // invalid beats sequence
      do_reset();
      step_nom(1, 3, 3, 3);
      drive(3, 3, 3, 7);
      tick();
      chk("pri2_code", 16'(fault_code), 16'd2);
      chk("pri2_dir", 16'(fault_dir), 16'b1000);

      // stuck: 64th equal cycle faults at its closing edge
      do_reset();
      drive(1, 3, 3, 3);
      tick();
      chk("stk_first", 16'(fault), 16'd0);
      for (int k = 1; k <= 63; k++) begin
         tick();
         chk("stk_hold", 16'(fault), 16'd0);
      end
      tick();
      chk("stk_fault", 16'(fault), 16'd1);
      chk("stk_code", 16'(fault_code), 16'd4);
      chk("stk_dir", 16'(fault_dir), 16'd0);

`ifdef TRAFFIC_FAULT_CLEAR_EN
      // fault_clr only works with all inputs red
      fault_clr = 1'b1;
      drive(1, 3, 3, 3);
      tick();
      chk("clr_ign_fault", 16'(fault), 16'd1);
      chk("clr_ign_code", 16'(fault_code), 16'd4);
      drive(3, 3, 3, 3);
      tick();
      fault_clr = 1'b0;
      chk("clr_fault", 16'(fault), 16'd0);
      chk("clr_code", 16'(fault_code), 16'd0);
      chk("clr_lamps", 16'(lamps_all), 16'(ALL_RED));
      run_nominal(1);
`endif

      // stuck: an input change on the 63rd equal cycle restarts the count
      do_reset();
      drive(1, 3, 3, 3);
      tick();
      for (int k = 1; k <= 62; k++) begin
         tick();
         chk("stk2_hold", 16'(fault), 16'd0);
      end
      drive(2, 3, 3, 3);
      tick();
      chk("stk2_change", 16'(fault), 16'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stk2_after", 16'(fault), 16'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
